if_fetch_stage: RTL and testbench

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_fetch_stage.sv | 147 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: issues in-order SRAM-like fetches, buffers responses
// in a small FIFO for decode, and cancels in-flight fetches on redirect.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h1c000000,
    parameter int          IBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_allowin,
    output logic        if_id_valid,
    output logic [64:0] if_id_bus,
    input  logic [32:0] id_if_bus,
    input  logic        ex_flush,
    input  logic [31:0] ex_entry,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);
    localparam int PW = $clog2(IBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]   DEPTH_X = (CW+1)'(IBUF_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   redir_target;
    logic          run_en;
    logic          req_hold;
    logic          redir_pend;
    logic          adef_done;
    logic [CW-1:0] ibuf_count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] cancel_cnt;
    logic [PW-1:0] ib_head, ib_tail;
    logic [PW-1:0] pp_head, pp_tail;
    logic [64:0]   ibuf    [IBUF_DEPTH];
    logic [31:0]   pend_pc [IBUF_DEPTH];

    logic          br_taken;
    logic [31:0]   br_target;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          pc_aligned;
    logic [CW:0]   occupancy;
    logic          accept;
    logic          resp;
    logic          resp_keep;
    logic          adef_push;
    logic          ib_push;
    logic          ib_pop;
    logic          held_redirect;
    logic [CW-1:0] out_next;
    logic [64:0]   push_entry;

    assign {br_taken, br_target} = id_if_bus;
    assign redirect    = ex_flush | br_taken;
    assign redirect_pc = ex_flush ? ex_entry : br_target;
    assign pc_aligned  = (fetch_pc[1:0] == 2'b00);
    assign occupancy   = {1'b0, ibuf_count} + {1'b0, outstanding};

    // Once raised, req stays up (same address) until the slave takes it.
    assign inst_sram_req   = run_en & (req_hold | (pc_aligned & ~redir_pend & (occupancy < DEPTH_X)));
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;
    assign inst_sram_addr  = fetch_pc;

    assign accept        = inst_sram_req & inst_sram_addr_ok;
    // A data_ok with nothing in flight is a leftover from before reset.
    assign resp          = inst_sram_data_ok & (outstanding != '0);
    assign resp_keep     = resp & (cancel_cnt == '0);
    assign adef_push     = run_en & ~pc_aligned & ~redir_pend & ~adef_done &
                           (outstanding == '0) & (cancel_cnt == '0) & (ibuf_count != DEPTH_C);
    assign ib_push       = resp_keep | adef_push;
    assign ib_pop        = if_id_valid & id_allowin;
    assign held_redirect = redirect & inst_sram_req & ~inst_sram_addr_ok;
    assign out_next      = outstanding + CW'(accept) - CW'(resp);
    assign push_entry    = adef_push ? {1'b1, fetch_pc, 32'h0}
                                     : {1'b0, pend_pc[pp_head], inst_sram_rdata};

    assign if_id_valid = (ibuf_count != '0);
    assign if_id_bus   = ibuf[ib_head];

    always_ff @(posedge clk) begin
        if (accept)  pend_pc[pp_tail] <= fetch_pc;
        if (ib_push) ibuf[ib_tail]    <= push_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc     <= RESET_PC;
            redir_target <= '0;
            run_en       <= 1'b0;
            req_hold     <= 1'b0;
            redir_pend   <= 1'b0;
            adef_done    <= 1'b0;
            ibuf_count   <= '0;
            outstanding  <= '0;
            cancel_cnt   <= '0;
            ib_head      <= '0;
            ib_tail      <= '0;
            pp_head      <= '0;
            pp_tail      <= '0;
        end else begin
            run_en      <= 1'b1;
            req_hold    <= inst_sram_req & ~inst_sram_addr_ok;
            outstanding <= out_next;
            if (accept)    pp_tail   <= pp_tail + PW'(1);
            if (resp)      pp_head   <= pp_head + PW'(1);
            if (adef_push) adef_done <= 1'b1;

            if (redirect) begin
                // Everything still in flight belongs to the old stream.
                ib_head    <= '0;
                ib_tail    <= '0;
                ibuf_count <= '0;
                cancel_cnt <= out_next;
                adef_done  <= 1'b0;
                if (held_redirect) begin
                    redir_pend   <= 1'b1;
                    redir_target <= redirect_pc;
                end else begin
                    redir_pend <= 1'b0;
                    fetch_pc   <= redirect_pc;
                end
            end else begin
                if (ib_push) ib_tail <= ib_tail + PW'(1);
                if (ib_pop)  ib_head <= ib_head + PW'(1);
                ibuf_count <= ibuf_count + CW'(ib_push) - CW'(ib_pop);
                if (accept && redir_pend) begin
                    cancel_cnt <= out_next;
                    fetch_pc   <= redir_target;
                    redir_pend <= 1'b0;
                end else begin
                    if (resp && (cancel_cnt != '0)) cancel_cnt <= cancel_cnt - CW'(1);
                    if (accept) fetch_pc <= fetch_pc + 32'd4;
                end
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: SRAM slave model plus a stream-level reference
// (sequential pcs from the last redirect target) checked at every decode pop.
module tb_if_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_allowin = 1'b0;
    logic        if_id_valid;
    logic [64:0] if_id_bus;
    logic [32:0] id_if_bus = '0;
    logic        ex_flush = 1'b0;
    logic [31:0] ex_entry = '0;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok = 1'b0;
    logic        inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = '0;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(RESET_PC), .IBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .id_allowin(id_allowin),
        .if_id_valid(if_id_valid), .if_id_bus(if_id_bus), .id_if_bus(id_if_bus),
        .ex_flush(ex_flush), .ex_entry(ex_entry),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pops     = 0;
    int          n_acc    = 0;
    logic [31:0] sq[$];
    logic [31:0] exp_pc   = RESET_PC;
    bit          exp_done = 1'b0;
    bit          held     = 1'b0;
    bit          b_pend   = 1'b0;
    logic [31:0] held_addr = '0;
    logic        s_valid, s_req;
    logic [64:0] s_bus;
    logic [31:0] s_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h0badf00d;
    endfunction

    function automatic bit rnd(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic check_val(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: sample at negedge, check against the model, then drive this cycle's inputs.
    task automatic cycle(input bit allow, input int aok_pct, input int dok_pct,
                         input bit br, input logic [31:0] br_t,
                         input bit exf, input logic [31:0] exe);
        logic [64:0] exp_bus;
        bit          aok;
        @(negedge clk);
        s_valid = if_id_valid;
        s_bus   = if_id_bus;
        s_req   = inst_sram_req;
        s_addr  = inst_sram_addr;
        check_val("write_side_const", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata},
                  {1'b0, 2'b10, 4'h0, 32'h0});
        if (held) begin
            check_val("req_held", s_req, 1'b1);
            check_val("addr_held", s_addr, held_addr);
        end
        if (s_req) check_val("req_addr_align", s_addr[1:0], 2'b00);
        if (exp_pc[1:0] != 2'b00 && !b_pend) check_val("adef_no_req", s_req, 1'b0);
        check_val("outstanding_limit", sq.size() <= DEPTH, 1'b1);

        if (s_valid && allow) begin
            if (exp_pc[1:0] != 2'b00 && exp_done) begin
                check_val("adef_stall_pop", s_valid, 1'b0);
            end else begin
                if (exp_pc[1:0] != 2'b00) begin
                    exp_bus  = {1'b1, exp_pc, 32'h0};
                    exp_done = 1'b1;
                end else begin
                    exp_bus = {1'b0, exp_pc, mem_word(exp_pc)};
                    exp_pc  = exp_pc + 32'd4;
                end
                check_val("pop_entry", s_bus, exp_bus);
            end
            pops++;
        end

        id_allowin = allow;
        if (sq.size() > 0 && rnd(dok_pct)) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = mem_word(sq.pop_front());
        end else begin
            inst_sram_data_ok = 1'b0;
            inst_sram_rdata   = $urandom;
        end
        aok = rnd(aok_pct);
        inst_sram_addr_ok = aok;
        if (s_req && aok) begin
            sq.push_back(s_addr);
            n_acc++;
        end
        held      = s_req && !aok;
        held_addr = s_addr;
        id_if_bus = {br, br_t};
        ex_flush  = exf;
        ex_entry  = exe;
        if (exf || br) begin
            exp_pc   = exf ? exe : br_t;
            exp_done = 1'b0;
            b_pend   = held;
        end else if (s_req && aok) begin
            b_pend = 1'b0;
        end
    endtask

    task automatic run(input int n, input bit allow, input int aok_pct, input int dok_pct);
        for (int i = 0; i < n; i++) cycle(allow, aok_pct, dok_pct, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] pc, output int lat);
        lat = 0;
        do begin
            cycle(1'b1, 100, 100, 1'b0, '0, 1'b0, '0);
            lat++;
        end while (!s_valid && lat < 30);
        check_val({tag, "_valid"}, s_valid, 1'b1);
        check_val({tag, "_pc"}, s_bus[63:32], pc);
    endtask

    task automatic do_reset(input bit stale);
        @(negedge clk);
        reset = 1'b1;
        id_allowin = 1'b0; inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
        id_if_bus = '0; ex_flush = 1'b0; ex_entry = '0; inst_sram_rdata = '0;
        #1;
        check_val("rst_valid", if_id_valid, 1'b0);
        check_val("rst_req", inst_sram_req, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        if (stale) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = 32'hdeadbeef;
        end
        #1;
        check_val("req_before_first_edge", inst_sram_req, 1'b0);
        sq.delete();
        held = 1'b0; b_pend = 1'b0; exp_pc = RESET_PC; exp_done = 1'b0;
    endtask

    initial begin
        int lat, k, p0;
        logic [31:0] a;

        // straight-line fetch, one-cycle responses
        do_reset(1'b0);
        wait_valid("seq0", RESET_PC, lat);
        check_val("no_bypass", lat >= 3, 1'b1);
        cycle(1'b1, 100, 100, 1'b0, '0, 1'b0, '0);
        check_val("seq1_valid", s_valid, 1'b1);
        check_val("seq1_pc", s_bus[63:32], RESET_PC + 32'd4);
        cycle(1'b1, 100, 100, 1'b0, '0, 1'b0, '0);
        check_val("seq2_valid", s_valid, 1'b1);
        check_val("seq2_pc", s_bus[63:32], RESET_PC + 32'd8);

        // decode stalled: buffer fills to DEPTH, then drains in order
        do_reset(1'b0);
        n_acc = 0;
        run(10, 1'b0, 100, 100);
        check_val("full_req_low", s_req, 1'b0);
        check_val("full_accepts", n_acc, DEPTH);
        p0 = pops;
        run(12, 1'b1, 0, 100);
        check_val("drain_count", pops - p0, DEPTH);
        check_val("drain_empty", s_valid, 1'b0);

        // branch with requests in flight
        do_reset(1'b0);
        k = 0;
        do begin cycle(1'b1, 100, 0, 1'b0, '0, 1'b0, '0); k++; end while (sq.size() < 3 && k < 10);
        check_val("three_outstanding", sq.size(), 3);
        cycle(1'b1, 100, 0, 1'b1, 32'h1c000100, 1'b0, '0);
        wait_valid("branch", 32'h1c000100, lat);

        // ex_flush beats a simultaneous branch
        do_reset(1'b0);
        run(5, 1'b1, 100, 50);
        cycle(1'b1, 100, 100, 1'b1, 32'h1c000200, 1'b1, 32'h1c008000);
        wait_valid("flush_prio", 32'h1c008000, lat);

        // misaligned target: single ADEF entry, then fetch stalls
        do_reset(1'b0);
        run(4, 1'b1, 100, 100);
        cycle(1'b1, 100, 100, 1'b1, 32'h1c000002, 1'b0, '0);
        wait_valid("adef", 32'h1c000002, lat);
        check_val("adef_entry", s_bus, {1'b1, 32'h1c000002, 32'h0});
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 100, 100, 1'b0, '0, 1'b0, '0);
            check_val("adef_stall_req", s_req, 1'b0);
            check_val("adef_stall_valid", s_valid, 1'b0);
        end
        cycle(1'b1, 100, 100, 1'b1, 32'h1c000010, 1'b0, '0);
        wait_valid("adef_exit", 32'h1c000010, lat);

        // redirect while a request is held without addr_ok
        do_reset(1'b0);
        run(4, 1'b1, 100, 100);
        k = 0;
        do begin cycle(1'b1, 0, 100, 1'b0, '0, 1'b0, '0); k++; end while (!s_req && k < 10);
        check_val("hold_req_seen", s_req, 1'b1);
        a = s_addr;
        cycle(1'b1, 0, 100, 1'b1, 32'h1c000400, 1'b0, '0);
        check_val("hold_addr1", s_addr, a);
        cycle(1'b1, 0, 100, 1'b0, '0, 1'b0, '0);
        check_val("hold_addr2", s_addr, a);
        cycle(1'b1, 100, 100, 1'b0, '0, 1'b0, '0);
        check_val("hold_addr3", s_addr, a);
        k = 0;
        do begin cycle(1'b1, 100, 100, 1'b0, '0, 1'b0, '0); k++; end while (!s_req && k < 10);
        check_val("latched_target_req", s_addr, 32'h1c000400);
        wait_valid("latched_target", 32'h1c000400, lat);

        // reset with requests in flight; stale data_ok afterwards is dropped
        run(3, 1'b1, 100, 0);
        do_reset(1'b1);
        wait_valid("post_reset", RESET_PC, lat);

        // randomized traffic and redirects
        p0 = pops;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t1, t2;
            t1 = RESET_PC + 32'($urandom_range(255)) * 32'd4 + (rnd(20) ? 32'($urandom_range(3, 1)) : 32'd0);
            t2 = 32'h1c010000 + 32'($urandom_range(255)) * 32'd4 + (rnd(20) ? 32'($urandom_range(3, 1)) : 32'd0);
            cycle(rnd(70), 70, 60, rnd(6), t1, rnd(3), t2);
        end
        check_val("random_progress", (pops - p0) > 50, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
